// File: rtl/cipher_pkg.sv
// Shared types and constants for the keystream cipher datapath: FSM state
// encodings, key width and the LFSR tap mask.
package cipher_pkg;

   localparam int KEY_W = 8;

   // Taps 7,5,4,3 implement x^8+x^6+x^5+x^4+1 in Fibonacci form.
   localparam logic [KEY_W-1:0] LFSR_TAPS = 8'hB8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WARMUP,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   function automatic logic [KEY_W-1:0] lfsr_next(input logic [KEY_W-1:0] q);
      return {q[KEY_W-2:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/keystream_lfsr.sv
// 8-bit keystream register: parallel seed load has priority over a step.
module keystream_lfsr
   import cipher_pkg::*;
(
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic [KEY_W-1:0] seed,
   input  logic             step,
   output logic [KEY_W-1:0] q
);

   logic [KEY_W-1:0] q_q;
   logic [KEY_W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = seed;
      end else if (step) begin
         q_d = lfsr_next(q_q);
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/keystream_cipher_ctrl.sv
// Message sequencer: latches seed/length, warms up the LFSR, then XORs each
// accepted byte with the current key through a one-deep output register.
module keystream_cipher_ctrl
   import cipher_pkg::*;
#(
   parameter int LEN_W  = 8,
   parameter int WARMUP = 2
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic [KEY_W-1:0] seed,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   input  logic [KEY_W-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [KEY_W-1:0] out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam logic [LEN_W-1:0] WARM_LAST = LEN_W'((WARMUP > 0) ? (WARMUP - 1) : 0);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [KEY_W-1:0] seed_q, seed_d;
   logic             out_valid_q, out_valid_d;
   logic [KEY_W-1:0] out_data_q, out_data_d;
   logic             error_q, error_d;
   logic             lfsr_load;
   logic             lfsr_step;
   logic [KEY_W-1:0] key;
   logic             accept;

   keystream_lfsr u_lfsr (
      .clk   (clk),
      .clear (clear),
      .load  (lfsr_load),
      .seed  (seed_q),
      .step  (lfsr_step),
      .q     (key)
   );

   // The output slot can take a new byte whenever it is empty or being drained.
   assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      len_d       = len_q;
      seed_d      = seed_q;
      error_d     = 1'b0;
      lfsr_load   = 1'b0;
      lfsr_step   = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (seed == '0) begin
                  error_d = 1'b1;
               end else if (len == '0) begin
                  state_d = ST_DONE;
               end else begin
                  seed_d  = seed;
                  len_d   = len;
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            lfsr_load = 1'b1;
            count_d   = '0;
            state_d   = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
         end
         ST_WARMUP: begin
            // count doubles as the warm-up step counter before the message starts.
            lfsr_step = 1'b1;
            if (count_q == WARM_LAST) begin
               count_d = '0;
               state_d = ST_RUN;
            end else begin
               count_d = count_q + LEN_W'(1);
            end
         end
         ST_RUN: begin
            if (accept) begin
               lfsr_step = 1'b1;
               count_d   = count_q + LEN_W'(1);
               if (count_q == len_q - LEN_W'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (!out_valid_q || out_ready) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data ^ key;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         len_q       <= '0;
         seed_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         len_q       <= len_d;
         seed_q      <= seed_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         error_q     <= error_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign error     = error_q;

endmodule
